// File: rtl/svc_uart_tx_arb.sv
// Line-locking round-robin arbiter in front of the UART TX byte port.
// One holder owns the port until newline, last flag, or idle timeout.
module svc_uart_tx_arb #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_EOL     = 1,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         s_valid,
    input  logic [NUM_REQ*8-1:0]       s_data,
    input  logic [NUM_REQ-1:0]         s_last,
    output logic [NUM_REQ-1:0]         s_ready,
    output logic                       m_valid,
    output logic [7:0]                 m_data,
    input  logic                       m_ready,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX =
        (LOCK_TIMEOUT > 0) ? CW'(LOCK_TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   idle_q, idle_d;
    logic            mv_q, mv_d;
    logic [7:0]      md_q, md_d;

    logic [IW-1:0]   win;
    logic            win_vld;
    logic [IW-1:0]   gnt_next;
    logic [7:0]      hold_byte;
    logic            hold_vld;
    logic            hold_last;
    logic            out_free;
    logic            accept;
    logic            tmo;

    // Scan downward so the lowest offset from rr_q is the final winner.
    always_comb begin
        int j;
        win     = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (s_valid[j]) begin
                win     = IW'(j);
                win_vld = 1'b1;
            end
        end
    end

    assign hold_byte = s_data[{gnt_q, 3'b000} +: 8];
    assign hold_vld  = s_valid[gnt_q];
    assign hold_last = s_last[gnt_q];
    assign out_free  = !mv_q || m_ready;
    assign accept    = (state_q == LOCKED) && hold_vld && out_free;
    assign tmo       = (LOCK_TIMEOUT != 0) && !hold_vld && (idle_q == CNT_MAX);
    assign gnt_next  = (gnt_q == LAST_IDX) ? '0 : gnt_q + IW'(1);

    assign s_ready   = ((state_q == LOCKED) && out_free) ?
                       (NUM_REQ'(1) << gnt_q) : '0;
    assign m_valid   = mv_q;
    assign m_data    = md_q;
    assign gnt_valid = (state_q == LOCKED);
    assign gnt_idx   = gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        idle_d  = idle_q;
        mv_d    = mv_q;
        md_d    = md_q;
        if (mv_q && m_ready) mv_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = LOCKED;
                    gnt_d   = win;
                    idle_d  = '0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    mv_d   = 1'b1;
                    md_d   = hold_byte;
                    idle_d = '0;
                    if (hold_last || (LOCK_EOL != 0 && hold_byte == 8'h0A)) begin
                        state_d = IDLE;
                        rr_d    = gnt_next;
                    end
                end else if (!hold_vld) begin
                    if (tmo) begin
                        state_d = IDLE;
                        rr_d    = gnt_next;
                    end else if (LOCK_TIMEOUT != 0 && idle_q != CNT_MAX) begin
                        idle_d = idle_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            idle_q  <= '0;
            mv_q    <= 1'b0;
            md_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            idle_q  <= idle_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
        end
    end
endmodule

// File: tb/tb_svc_uart_tx_arb.sv
// Bench for svc_uart_tx_arb: directed line scenarios plus random traffic
// checked cycle by cycle against a behavioural model of the arbiter.
module tb_svc_uart_tx_arb;
    localparam int N  = 2;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   s_valid;
    logic [N*8-1:0] s_data;
    logic [N-1:0]   s_last;
    logic [N-1:0]   s_ready;
    logic           m_valid;
    logic [7:0]     m_data;
    logic           m_ready;
    logic           gnt_valid;
    logic [0:0]     gnt_idx;

    svc_uart_tx_arb #(
        .NUM_REQ(N),
        .LOCK_EOL(1),
        .LOCK_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_ready(m_ready),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // requester traffic: {last, byte}
    logic [8:0] txq [N][$];
    bit         pres [N];
    int         stall [N];
    bit         rnd_mode = 0;
    logic [7:0] got [$];

    // behavioural model of the arbiter
    bit         locked;
    int         gi, ptr, idle;
    bit         mv;
    logic [7:0] md;

    task automatic model_reset();
        locked = 0; gi = 0; ptr = 0; idle = 0; mv = 0; md = 8'h00;
    endtask

    task automatic model_step(input logic [N-1:0] acc);
        bit accd;
        bit found;
        int j;
        logic [7:0] b;
        if (rst) begin
            model_reset();
            return;
        end
        accd = 0;
        if (!locked) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (!found && s_valid[j]) begin
                    found = 1; gi = j; idle = 0;
                end
            end
            locked = found;
        end else if (acc[gi]) begin
            b = s_data[8*gi +: 8];
            accd = 1; idle = 0;
            if (s_last[gi] || b == 8'h0A) begin
                locked = 0; ptr = (gi + 1) % N;
            end
            md = b;
        end else if (!s_valid[gi]) begin
            if (idle == TO - 1) begin
                locked = 0; ptr = (gi + 1) % N;
            end else begin
                idle++;
            end
        end
        if (accd) mv = 1;
        else if (mv && m_ready) mv = 0;
    endtask

    task automatic drive();
        logic [8:0] it;
        for (int i = 0; i < N; i++) begin
            if (!pres[i] && txq[i].size() > 0) begin
                if (!rnd_mode) pres[i] = 1;
                else if (stall[i] > 0) stall[i]--;
                else if ($urandom_range(15) == 0) stall[i] = $urandom_range(12, 4);
                else if ($urandom_range(3) != 0) pres[i] = 1;
            end
            it = pres[i] ? txq[i][0] : 9'($urandom);
            s_valid[i]      = pres[i];
            s_data[8*i +: 8] = it[7:0];
            s_last[i]       = it[8];
        end
        if (rnd_mode) m_ready = ($urandom_range(9) < 7);
    endtask

    task automatic tick();
        logic [N-1:0] er, acc;
        @(negedge clk);
        er = '0;
        if (locked && (!mv || m_ready)) er[gi] = 1'b1;
        acc = rst ? '0 : (er & s_valid);
        check("gnt_valid", 32'(gnt_valid), 32'(locked));
        check("gnt_idx", 32'(gnt_idx), gi);
        check("m_valid", 32'(m_valid), 32'(mv));
        check("m_data", 32'(m_data), 32'(md));
        check("s_ready", 32'(s_ready), 32'(er));
        if (m_valid && m_ready) got.push_back(m_data);
        @(posedge clk);
        model_step(acc);
        for (int i = 0; i < N; i++)
            if (acc[i]) begin
                void'(txq[i].pop_front());
                pres[i] = 0;
            end
        #1 drive();
    endtask

    function automatic bit busy();
        bit b = locked || mv;
        for (int i = 0; i < N; i++) if (txq[i].size() > 0) b = 1;
        return b;
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        while (busy() && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(busy()), 0);
    endtask

    task automatic push_str(input int r, input string s);
        for (int k = 0; k < s.len(); k++) txq[r].push_back({1'b0, s[k]});
    endtask

    task automatic check_got(input string tag, input string s);
        check({tag, "_len"}, got.size(), s.len());
        for (int k = 0; k < s.len() && k < got.size(); k++)
            check({tag, "_byte"}, 32'(got[k]), 32'(s[k]));
        got.delete();
    endtask

    task automatic pulse_reset();
        rst = 1;
        tick();
        rst = 0;
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_gnt_valid", 32'(gnt_valid), 0);
    endtask

    initial begin
        rst = 1; m_ready = 1; s_valid = '0; s_data = '0; s_last = '0;
        for (int i = 0; i < N; i++) begin pres[i] = 0; stall[i] = 0; end
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        check("reset_gnt_valid", 32'(gnt_valid), 0);
        check("reset_gnt_idx", 32'(gnt_idx), 0);
        check("reset_m_valid", 32'(m_valid), 0);
        check("reset_m_data", 32'(m_data), 0);
        check("reset_s_ready", 32'(s_ready), 0);
        @(posedge clk);
        #1 rst = 0;
        drive();

        push_str(0, "hi\n");
        drive();
        drain("hi");
        check_got("hi", "hi\n");

        pulse_reset();
        push_str(0, "AB\n");
        push_str(1, "xy\n");
        drive();
        drain("contend");
        check_got("contend", "AB\nxy\n");

        push_str(0, "abcdef\n");
        drive();
        repeat (3) tick();
        m_ready = 0;
        repeat (5) tick();
        m_ready = 1;
        drain("bp");
        check_got("bp", "abcdef\n");

        txq[1].push_back({1'b1, 8'h41});
        drive();
        tick();
        push_str(0, "Z\n");
        drain("last");
        check_got("last", "AZ\n");

        push_str(0, "A");
        drive();
        repeat (4) tick();
        push_str(1, "q\n");
        drain("timeout");
        check_got("timeout", "Aq\n");

        push_str(0, "hello\n");
        m_ready = 0;
        drive();
        repeat (4) tick();
        pulse_reset();
        m_ready = 1;
        drain("midrst");
        check_got("midrst", "ello\n");

        for (int i = 0; i < N; i++)
            for (int l = 0; l < 10; l++) begin
                int len = $urandom_range(6, 1);
                for (int k = 0; k < len; k++) begin
                    logic [7:0] b = 8'($urandom);
                    if (b == 8'h0A) b = 8'h0B;
                    txq[i].push_back({1'b0, b});
                end
                if ($urandom_range(1) == 0) txq[i].push_back({1'b0, 8'h0A});
                else txq[i][$] = {1'b1, txq[i][$][7:0]};
            end
        rnd_mode = 1;
        begin
            int n = 0;
            while (busy() && n < 20000) begin
                tick();
                n++;
            end
        end
        rnd_mode = 0;
        m_ready = 1;
        drain("random");
        got.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
